// File: rtl/alu32_seq.sv
// ---------------------------------------------------------------------------
// alu32_seq -- byte-serial 32-bit ALU with an x86-style EFLAGS image.
//
// A request is captured in IDLE and processed one byte per cycle over four
// EXEC cycles, with the carry chained through a 1-bit register. The result
// is then held in DONE until the consumer takes it.
//
// Ports
//   CLK        in   1  sole clock, rising edge
//   RST        in   1  asynchronous reset, active-high
//   in_valid   in   1  request present
//   in_ready   out  1  request accepted on this edge when high with in_valid
//   op         in   3  0 ADD, 1 OR, 2 NOT, 3 DAA, 4 AND, 5 CLD, 6 SUB, 7 STD
//   a, b       in  32  operands (SUB computes b - a)
//   flags_in   in  32  EFLAGS image; bits not touched by op pass through
//   out_valid  out  1  result present (DONE state)
//   out_ready  in   1  result consumed
//   alu_out    out 32  result
//   flags_out  out 32  updated EFLAGS image
//   busy       out  1  high whenever the FSM is not IDLE
// ---------------------------------------------------------------------------
module alu32_seq (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] flags_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_out,
  output logic [31:0] flags_out,
  output logic        busy
);

  localparam int F_CF = 0;
  localparam int F_PF = 2;
  localparam int F_AF = 4;
  localparam int F_ZF = 6;
  localparam int F_SF = 7;
  localparam int F_DF = 10;
  localparam int F_OF = 11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_OR  = 3'd1,
    OP_NOT = 3'd2,
    OP_DAA = 3'd3,
    OP_AND = 3'd4,
    OP_CLD = 3'd5,
    OP_SUB = 3'd6,
    OP_STD = 3'd7
  } op_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [1:0]  r_cnt;
  logic        r_carry;
  logic        r_af;
  op_e         r_op;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_flags;
  logic [31:0] r_res;
  logic [31:0] r_flags_out;

  // Byte lanes of the captured operands.
  logic [7:0] w_a_bytes [4];
  logic [7:0] w_b_bytes [4];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lanes
      assign w_a_bytes[gi] = r_a[8*gi +: 8];
      assign w_b_bytes[gi] = r_b[8*gi +: 8];
    end
  endgenerate

  logic [7:0]  w_a_k;
  logic [7:0]  w_b_k;
  logic        w_is_sub;
  logic [7:0]  w_x;
  logic        w_cin;
  logic [8:0]  w_sum9;
  logic        w_nib_carry;
  logic        w_daa_lo_adj;
  logic        w_daa_hi_adj;
  logic [7:0]  w_daa_al1;
  logic [7:0]  w_daa_al;
  logic [7:0]  w_byte_res;
  logic [31:0] w_res_full;
  logic [31:0] w_flags_final;

  assign w_a_k    = w_a_bytes[r_cnt];
  assign w_b_k    = w_b_bytes[r_cnt];
  assign w_is_sub = (r_op == OP_SUB);

  // SUB is b + ~a + 1: the +1 enters as the carry-in of byte 0.
  assign w_x    = w_is_sub ? ~w_a_k : w_a_k;
  assign w_cin  = (r_cnt == 2'd0) ? w_is_sub : r_carry;
  assign w_sum9 = {1'b0, w_x} + {1'b0, w_b_k} + {8'd0, w_cin};

  // Carry into bit 4 recovered from the byte sum; meaningful on byte 0 only.
  assign w_nib_carry = w_sum9[4] ^ w_x[4] ^ w_b_k[4];

  // DAA decisions use the original AL and the captured AF/CF, so they stay
  // valid for the whole operation and can also drive the final flags.
  assign w_daa_lo_adj = (r_a[3:0] > 4'd9) || r_flags[F_AF];
  assign w_daa_al1    = w_daa_lo_adj ? (r_a[7:0] + 8'h06) : r_a[7:0];
  assign w_daa_hi_adj = (r_a[7:0] > 8'h99) || r_flags[F_CF];
  assign w_daa_al     = w_daa_hi_adj ? (w_daa_al1 + 8'h60) : w_daa_al1;

  always_comb begin
    w_byte_res = w_a_k;
    case (r_op)
      OP_ADD, OP_SUB: w_byte_res = w_sum9[7:0];
      OP_OR:          w_byte_res = w_a_k | w_b_k;
      OP_AND:         w_byte_res = w_a_k & w_b_k;
      OP_NOT:         w_byte_res = ~w_a_k;
      OP_DAA:         w_byte_res = (r_cnt == 2'd0) ? w_daa_al : w_a_k;
      default:        w_byte_res = w_a_k;
    endcase
  end

  // Full result as it will stand after the last byte (valid when r_cnt==3).
  assign w_res_full = {w_byte_res, r_res[23:0]};

  always_comb begin
    w_flags_final = r_flags;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_flags_final[F_CF] = w_sum9[8];
        w_flags_final[F_AF] = r_af;
        if (r_op == OP_ADD)
          w_flags_final[F_OF] = (r_a[31] == r_b[31]) && (w_res_full[31] != r_a[31]);
        else
          w_flags_final[F_OF] = (r_a[31] != r_b[31]) && (w_res_full[31] != r_b[31]);
        w_flags_final[F_ZF] = (w_res_full == 32'd0);
        w_flags_final[F_SF] = w_res_full[31];
        w_flags_final[F_PF] = ~^w_res_full[7:0];
      end
      OP_OR, OP_AND: begin
        w_flags_final[F_CF] = 1'b0;
        w_flags_final[F_OF] = 1'b0;
        w_flags_final[F_ZF] = (w_res_full == 32'd0);
        w_flags_final[F_SF] = w_res_full[31];
        w_flags_final[F_PF] = ~^w_res_full[7:0];
      end
      OP_DAA: begin
        w_flags_final[F_AF] = w_daa_lo_adj;
        w_flags_final[F_CF] = w_daa_hi_adj;
      end
      OP_CLD:  w_flags_final[F_DF] = 1'b0;
      OP_STD:  w_flags_final[F_DF] = 1'b1;
      default: w_flags_final = r_flags;
    endcase
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_state_next = S_EXEC;
      S_EXEC: if (r_cnt == 2'd3) w_state_next = S_DONE;
      S_DONE: if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt       <= 2'd0;
      r_carry     <= 1'b0;
      r_af        <= 1'b0;
      r_op        <= OP_ADD;
      r_a         <= 32'd0;
      r_b         <= 32'd0;
      r_flags     <= 32'd0;
      r_res       <= 32'd0;
      r_flags_out <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_op    <= op_e'(op);
            r_a     <= a;
            r_b     <= b;
            r_flags <= flags_in;
            r_cnt   <= 2'd0;
            r_carry <= 1'b0;
          end
        end
        S_EXEC: begin
          r_res[{r_cnt, 3'b000} +: 8] <= w_byte_res;
          r_carry <= w_sum9[8];
          if (r_cnt == 2'd0) r_af <= w_nib_carry;
          if (r_cnt == 2'd3) r_flags_out <= w_flags_final;
          r_cnt <= r_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  // in_ready is gated by RST so it reads low for the whole reset pulse.
  assign in_ready  = (r_state == S_IDLE) && !RST;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign alu_out   = r_res;
  assign flags_out = r_flags_out;

endmodule
